// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer:
// opcodes, FSM states, ALU and store-width codes, IR field bundle.
package riscv_ctrl_pkg;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd7
   } state_t;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [2:0] F3_SRX  = 3'b101;

   localparam logic [2:0] SW_BYTE = 3'b000;
   localparam logic [2:0] SW_HALF = 3'b001;
   localparam logic [2:0] SW_WORD = 3'b010;

   // Only the instruction fields the sequencer looks at are kept.
   typedef struct packed {
      logic       f7_5;
      logic [4:0] rd;
      logic [2:0] f3;
      logic [6:0] opcode;
   } ir_t;

   function automatic ir_t ir_fields(input logic [31:0] instr);
      ir_t f;
      f.f7_5   = instr[30];
      f.rd     = instr[11:7];
      f.f3     = instr[14:12];
      f.opcode = instr[6:0];
      return f;
   endfunction

   function automatic logic opc_legal(input logic [6:0] opc);
      return (opc == OPC_R) || (opc == OPC_I) ||
             (opc == OPC_LOAD) || (opc == OPC_STORE);
   endfunction

endpackage

// File: rtl/alu_sel_dec.sv
// ALUSel / ALUSrc decode from opcode, funct3 and funct7[5].
// Loads, stores and anything else default to ADD with immediate.
module alu_sel_dec
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [4:0] alu_sel,
   output logic       alu_src
);

   always_comb begin
      alu_sel = ALU_ADD;
      alu_src = 1'b1;
      unique case (1'b1)
         (opcode == OPC_R): begin
            alu_sel = {1'b0, funct7_5, funct3};
            alu_src = 1'b0;
         end
         (opcode == OPC_I): begin
            alu_sel = {1'b0,
                       (funct3 == F3_SRX) ? funct7_5 : 1'b0,
                       funct3};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: fetch/decode/exec/mem/wb FSM with
// memory handshake timeouts, one-cycle enables and retire counter.
module multicycle_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_i,
   input  logic        imem_ready_i,
   input  logic        dmem_ready_i,
   output logic        imem_req_o,
   output logic        ir_we_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [2:0]  sel_store_o,
   output logic [4:0]  alu_sel_o,
   output logic        alu_src_o,
   output logic        mem_to_reg_o,
   output logic        reg_we_o,
   output logic        pc_we_o,
   output logic [2:0]  state_o,
   output logic        illegal_o,
   output logic        timeout_o,
   output logic [31:0] instret_o
);

   state_t           state_q;
   ir_t              ir_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      instret_q;
   logic             illegal_q;
   logic             timeout_q;

   logic       is_load;
   logic       is_store;
   logic       cnt_hit;
   logic [4:0] dec_sel;
   logic       dec_src;
   logic       unused_instr;

   assign is_load  = (ir_q.opcode == OPC_LOAD);
   assign is_store = (ir_q.opcode == OPC_STORE);
   // Last unacknowledged cycle allowed; a ready in this cycle still wins.
   assign cnt_hit  = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

   assign unused_instr = ^{instr_i[31], instr_i[29:15]};

   alu_sel_dec u_alu_sel_dec (
      .opcode   (ir_q.opcode),
      .funct3   (ir_q.f3),
      .funct7_5 (ir_q.f7_5),
      .alu_sel  (dec_sel),
      .alu_src  (dec_src)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         ir_q      <= '0;
         cnt_q     <= '0;
         instret_q <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         if (pc_we_o) begin
            instret_q <= instret_q + 32'd1;
         end
         case (state_q)
            ST_FETCH: begin
               if (imem_ready_i) begin
                  ir_q    <= ir_fields(instr_i);
                  state_q <= ST_DECODE;
               end else if (cnt_hit) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_TRAP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DECODE: begin
               if (opc_legal(ir_q.opcode)) begin
                  state_q <= ST_EXEC;
               end else begin
                  illegal_q <= 1'b1;
                  state_q   <= ST_TRAP;
               end
            end
            ST_EXEC: begin
               if (is_load || is_store) begin
                  cnt_q   <= '0;
                  state_q <= ST_MEM;
               end else begin
                  state_q <= ST_WB;
               end
            end
            ST_MEM: begin
               if (dmem_ready_i) begin
                  if (is_store) begin
                     cnt_q   <= '0;
                     state_q <= ST_FETCH;
                  end else begin
                     state_q <= ST_WB;
                  end
               end else if (cnt_hit) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_TRAP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_WB: begin
               cnt_q   <= '0;
               state_q <= ST_FETCH;
            end
            default: state_q <= ST_TRAP;
         endcase
      end
   end

   always_comb begin
      imem_req_o   = 1'b0;
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      sel_store_o  = '0;
      alu_sel_o    = '0;
      alu_src_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_we_o     = 1'b0;
      pc_we_o      = 1'b0;
      case (state_q)
         ST_FETCH: imem_req_o = 1'b1;
         ST_EXEC: begin
            alu_sel_o = dec_sel;
            alu_src_o = dec_src;
         end
         ST_MEM: begin
            dmem_req_o = 1'b1;
            if (is_store) begin
               dmem_we_o   = 1'b1;
               sel_store_o = ir_q.f3;
               pc_we_o     = dmem_ready_i;
            end
         end
         ST_WB: begin
            reg_we_o     = (ir_q.rd != 5'd0);
            mem_to_reg_o = is_load;
            pc_we_o      = 1'b1;
         end
         default: ;
      endcase
   end

   assign ir_we_o   = (state_q == ST_FETCH) & imem_ready_i;
   assign state_o   = state_q;
   assign illegal_o = illegal_q;
   assign timeout_o = timeout_q;
   assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors
// compared against hand-derived expectations.
module tb_multicycle_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] instr_i;
   logic        imem_ready_i;
   logic        dmem_ready_i;
   logic        imem_req_o;
   logic        ir_we_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [2:0]  sel_store_o;
   logic [4:0]  alu_sel_o;
   logic        alu_src_o;
   logic        mem_to_reg_o;
   logic        reg_we_o;
   logic        pc_we_o;
   logic [2:0]  state_o;
   logic        illegal_o;
   logic        timeout_o;
   logic [31:0] instret_o;

   int errors = 0;
   int checks = 0;

   multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_i      (instr_i),
      .imem_ready_i (imem_ready_i),
      .dmem_ready_i (dmem_ready_i),
      .imem_req_o   (imem_req_o),
      .ir_we_o      (ir_we_o),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .sel_store_o  (sel_store_o),
      .alu_sel_o    (alu_sel_o),
      .alu_src_o    (alu_src_o),
      .mem_to_reg_o (mem_to_reg_o),
      .reg_we_o     (reg_we_o),
      .pc_we_o      (pc_we_o),
      .state_o      (state_o),
      .illegal_o    (illegal_o),
      .timeout_o    (timeout_o),
      .instret_o    (instret_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector layout: state, imem_req, ir_we, dmem_req, dmem_we,
   // sel_store, alu_sel, alu_src, mem_to_reg, reg_we, pc_we.
   function automatic logic [18:0] ev(
      input int st, input int ireq, input int irwe,
      input int dreq, input int dwe, input int ss,
      input int as, input int asrc, input int m2r,
      input int rwe, input int pwe);
      return {3'(st), 1'(ireq), 1'(irwe), 1'(dreq),
              1'(dwe), 3'(ss), 5'(as), 1'(asrc),
              1'(m2r), 1'(rwe), 1'(pwe)};
   endfunction

   function automatic logic [18:0] obs();
      return {state_o, imem_req_o, ir_we_o, dmem_req_o,
              dmem_we_o, sel_store_o, alu_sel_o, alu_src_o,
              mem_to_reg_o, reg_we_o, pc_we_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic async_rst();
      rst = 1'b1;
      #1;
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1;
      rst = 1'b0;
      imem_ready_i = 1'b0;
      dmem_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [18:0] e;
      e = ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL reset_out got=%h exp=%h", obs(), e);
      end
      checks++;
      if ({illegal_o, timeout_o, instret_o} !== 34'd0) begin
         errors++;
         $display("FAIL reset_cnt got=%b/%b/%h exp=0/0/0",
                  illegal_o, timeout_o, instret_o);
      end
      release_rst();
      #1;
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL reset_rel got=%h exp=%h", obs(), e);
      end
   endtask

   task automatic test_add();
      logic [18:0] e [4];
      e[0] = ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      e[1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      e[2] = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      e[3] = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      instr_i = 32'h002081B3;
      for (int i = 0; i < 4; i++) begin
         imem_ready_i = 1'b1;
         dmem_ready_i = 1'b1;
         #1;
         checks++;
         if (obs() !== e[i]) begin
            errors++;
            $display("FAIL add c%0d got=%h exp=%h", i, obs(), e[i]);
         end
         tick();
      end
      imem_ready_i = 1'b0;
      dmem_ready_i = 1'b0;
      checks++;
      if (instret_o !== 32'd1 || state_o !== 3'd0) begin
         errors++;
         $display("FAIL add_ret got=%0d st=%0d exp=1 st=0",
                  instret_o, state_o);
      end
   endtask

   task automatic test_srai();
      logic [18:0] e [4];
      e[0] = ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      e[1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      e[2] = ev(2, 0, 0, 0, 0, 0, 5'b01101, 1, 0, 0, 0);
      e[3] = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      instr_i = 32'h4032D293;
      for (int i = 0; i < 4; i++) begin
         imem_ready_i = (i == 0);
         dmem_ready_i = 1'b0;
         #1;
         checks++;
         if (obs() !== e[i]) begin
            errors++;
            $display("FAIL srai c%0d got=%h exp=%h", i, obs(), e[i]);
         end
         tick();
      end
      checks++;
      if (instret_o !== 32'd2) begin
         errors++;
         $display("FAIL srai_ret got=%0d exp=2", instret_o);
      end
   endtask

   task automatic test_lw_wait();
      logic [18:0] e [8];
      e[0] = ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      e[1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      e[2] = ev(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 3; i < 7; i++)
         e[i] = ev(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      e[7] = ev(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
      instr_i = 32'h0080A203;
      for (int i = 0; i < 8; i++) begin
         imem_ready_i = (i == 0);
         dmem_ready_i = (i == 6);
         #1;
         checks++;
         if (obs() !== e[i]) begin
            errors++;
            $display("FAIL lw c%0d got=%h exp=%h", i, obs(), e[i]);
         end
         tick();
      end
      checks++;
      if (instret_o !== 32'd3 || state_o !== 3'd0) begin
         errors++;
         $display("FAIL lw_ret got=%0d st=%0d exp=3 st=0",
                  instret_o, state_o);
      end
   endtask

   task automatic test_sw();
      logic [18:0] e [4];
      e[0] = ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      e[1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      e[2] = ev(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      e[3] = ev(3, 0, 0, 1, 1, 3'b010, 0, 0, 0, 0, 1);
      instr_i = 32'h0020A223;
      for (int i = 0; i < 4; i++) begin
         imem_ready_i = (i == 0);
         dmem_ready_i = (i >= 2);
         #1;
         checks++;
         if (obs() !== e[i]) begin
            errors++;
            $display("FAIL sw c%0d got=%h exp=%h", i, obs(), e[i]);
         end
         tick();
      end
      dmem_ready_i = 1'b0;
      checks++;
      if (instret_o !== 32'd4 || state_o !== 3'd0) begin
         errors++;
         $display("FAIL sw_ret got=%0d st=%0d exp=4 st=0",
                  instret_o, state_o);
      end
   endtask

   task automatic test_ready_at_limit();
      logic [18:0] e;
      instr_i = 32'h00000013;
      for (int i = 0; i < 18; i++) begin
         if (i < 14) e = ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         else if (i == 14) e = ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         else if (i == 15) e = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         else if (i == 16) e = ev(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
         else e = ev(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
         imem_ready_i = (i == 14);
         dmem_ready_i = 1'b0;
         #1;
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL limit c%0d got=%h exp=%h", i, obs(), e);
         end
         tick();
      end
      checks++;
      if (instret_o !== 32'd5 || timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL limit_ret got=%0d/%b exp=5/0",
                  instret_o, timeout_o);
      end
   endtask

   task automatic test_illegal();
      logic [18:0] e [5];
      e[0] = ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      e[1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 2; i < 5; i++)
         e[i] = ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      instr_i = 32'h00000063;
      for (int i = 0; i < 5; i++) begin
         imem_ready_i = (i != 1);
         dmem_ready_i = (i >= 2);
         #1;
         checks++;
         if (obs() !== e[i]) begin
            errors++;
            $display("FAIL ill c%0d got=%h exp=%h", i, obs(), e[i]);
         end
         tick();
      end
      checks++;
      if ({illegal_o, timeout_o} !== 2'b10 || instret_o !== 32'd5) begin
         errors++;
         $display("FAIL ill_flags got=%b%b/%0d exp=10/5",
                  illegal_o, timeout_o, instret_o);
      end
      async_rst();
      checks++;
      if (state_o !== 3'd0 || illegal_o !== 1'b0 ||
          instret_o !== 32'd0) begin
         errors++;
         $display("FAIL ill_rst got=%0d/%b/%0d exp=0/0/0",
                  state_o, illegal_o, instret_o);
      end
      release_rst();
   endtask

   task automatic test_fetch_timeout();
      logic [18:0] e;
      e = ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) begin
         imem_ready_i = 1'b0;
         #1;
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL fto c%0d got=%h exp=%h", i, obs(), e);
         end
         tick();
      end
      e = ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      imem_ready_i = 1'b1;
      #1;
      checks++;
      if (obs() !== e || {illegal_o, timeout_o} !== 2'b01) begin
         errors++;
         $display("FAIL fto_trap got=%h/%b%b exp=%h/01",
                  obs(), illegal_o, timeout_o, e);
      end
      tick();
      async_rst();
      checks++;
      if (state_o !== 3'd0 || timeout_o !== 1'b0 ||
          imem_req_o !== 1'b1) begin
         errors++;
         $display("FAIL fto_rst got=%0d/%b/%b exp=0/0/1",
                  state_o, timeout_o, imem_req_o);
      end
      release_rst();
   endtask

   task automatic test_dmem_timeout();
      logic [18:0] e;
      instr_i = 32'h0080A203;
      for (int i = 0; i < 18; i++) begin
         if (i == 0) e = ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         else if (i == 1) e = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         else if (i == 2) e = ev(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
         else e = ev(3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
         imem_ready_i = (i == 0);
         dmem_ready_i = 1'b0;
         #1;
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL dto c%0d got=%h exp=%h", i, obs(), e);
         end
         tick();
      end
      e = ev(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      dmem_ready_i = 1'b1;
      #1;
      checks++;
      if (obs() !== e || timeout_o !== 1'b1 || instret_o !== 32'd0) begin
         errors++;
         $display("FAIL dto_trap got=%h/%b/%0d exp=%h/1/0",
                  obs(), timeout_o, instret_o, e);
      end
      tick();
      async_rst();
      release_rst();
   endtask

   task automatic test_reset_mid_mem();
      instr_i = 32'h002081B3;
      for (int i = 0; i < 4; i++) begin
         imem_ready_i = (i == 0);
         tick();
      end
      instr_i = 32'h0080A203;
      for (int i = 0; i < 5; i++) begin
         imem_ready_i = (i == 0);
         dmem_ready_i = 1'b0;
         tick();
      end
      checks++;
      if (state_o !== 3'd3 || dmem_req_o !== 1'b1 ||
          instret_o !== 32'd1) begin
         errors++;
         $display("FAIL mid_pre got=%0d/%b/%0d exp=3/1/1",
                  state_o, dmem_req_o, instret_o);
      end
      async_rst();
      checks++;
      if (state_o !== 3'd0 || dmem_req_o !== 1'b0 ||
          instret_o !== 32'd0 || timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst got=%0d/%b/%0d/%b exp=0/0/0/0",
                  state_o, dmem_req_o, instret_o, timeout_o);
      end
      release_rst();
   endtask

   initial begin
      rst = 1'b1;
      instr_i = 32'd0;
      imem_ready_i = 1'b0;
      dmem_ready_i = 1'b0;
      test_reset();
      test_add();
      test_srai();
      test_lw_wait();
      test_sw();
      test_ready_at_limit();
      test_illegal();
      test_fetch_timeout();
      test_dmem_timeout();
      test_reset_mid_mem();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
